// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the fetch front end: opcode constants, reset PC
// default and the packed layout of one instruction-queue entry.
package cpu_defs;

  localparam logic [6:0]  OPCODE_JAL       = 7'b1101111;
  localparam logic [31:0] INST_NOP         = 32'h00000013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h00000000;

  // One queue slot: fetched word, its PC, and the PC predicted to follow it.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred_pc;
  } iq_entry_t;

  localparam int IQ_ENTRY_W = $bits(iq_entry_t);

endpackage

// File: rtl/inst_queue.sv
// Parameterised circular FIFO holding fetched instructions. Head data is
// shown combinationally and forced to zero while the queue is empty.
module inst_queue
  import cpu_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = IQ_ENTRY_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_CNT);
  assign count     = r_count;
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign head_data = empty ? '0 : r_mem[r_head];

  // Pointer and occupancy update; flush empties the queue and drops any
  // push or pop presented in the same cycle. rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push_ok) r_tail <= r_tail + 1'b1;
        if (w_pop_ok)  r_head <= r_head + 1'b1;
        case ({w_push_ok, w_pop_ok})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage write at the tail; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !flush && w_push_ok) begin
      r_mem[r_tail] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word fetches, predicts
// the next PC (JAL taken, otherwise pc+4) and queues fetched words.
//
// Fetch handshake: inst_valid/inst_addr form a request that stays stable
// until accepted; a transfer happens on a clock edge where inst_valid and
// inst_ready are both high (and rdy is high). inst_ready may be asserted in
// the request cycle (hit) or any number of cycles later (miss fill).
module fetch_unit
  import cpu_defs::*;
#(
  parameter int          IQ_DEPTH = 4,
  parameter int          IQ_AW    = 2,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_addr,
  input  logic        inst_ready,
  input  logic [31:0] inst_res,
  output logic        iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  output logic [31:0] iq_pred_pc,
  input  logic        iq_pop
);

  logic [31:0]       r_pc;
  logic              w_accept;
  logic              w_pop;
  logic              w_is_jal;
  logic [31:0]       w_jal_imm;
  logic [31:0]       w_pred_pc;
  iq_entry_t         w_push_entry;
  iq_entry_t         w_head_entry;
  logic [IQ_ENTRY_W-1:0] w_head_bits;
  logic              w_empty;
  logic              w_full;
  logic [IQ_AW:0]    w_count;

  // Request whenever there is room; suppressed during reset and flush.
  assign inst_valid = !rst && !clear && !w_full;
  assign inst_addr  = r_pc;
  assign w_accept   = inst_valid && inst_ready;
  assign w_pop      = iq_pop && !w_empty;

  // Next-PC prediction from the word arriving this cycle.
  always_comb begin
    w_is_jal  = (inst_res[6:0] == OPCODE_JAL);
    w_jal_imm = {{12{inst_res[31]}}, inst_res[19:12], inst_res[20],
                 inst_res[30:21], 1'b0};
    w_pred_pc = w_is_jal ? (r_pc + w_jal_imm) : (r_pc + 32'd4);
  end

  assign w_push_entry.inst    = inst_res;
  assign w_push_entry.pc      = r_pc;
  assign w_push_entry.pred_pc = w_pred_pc;

  // PC register: redirect on flush, advance to the prediction on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (rdy) begin
      if (clear) begin
        r_pc <= redirect_pc;
      end else if (w_accept) begin
        r_pc <= w_pred_pc;
      end
    end
  end

  inst_queue #(
    .DEPTH (IQ_DEPTH),
    .AW    (IQ_AW),
    .W     (IQ_ENTRY_W)
  ) u_iq (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .flush     (clear),
    .push      (w_accept),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .head_data (w_head_bits),
    .empty     (w_empty),
    .full      (w_full),
    .count     (w_count)
  );

  assign w_head_entry = w_head_bits;
  assign iq_valid     = (w_count != '0);
  assign iq_inst      = w_head_entry.inst;
  assign iq_pc        = w_head_entry.pc;
  assign iq_pred_pc   = w_head_entry.pred_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential hits, JAL prediction,
// miss wait, stalls, simultaneous push/pop and flush.
module tb_fetch_unit;
  import cpu_defs::*;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic [31:0] inst_res;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic [31:0] iq_pred_pc;
  logic        iq_pop;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.IQ_DEPTH(4), .IQ_AW(2), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .clear       (clear),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_addr   (inst_addr),
    .inst_ready  (inst_ready),
    .inst_res    (inst_res),
    .iq_valid    (iq_valid),
    .iq_inst     (iq_inst),
    .iq_pc       (iq_pc),
    .iq_pred_pc  (iq_pred_pc),
    .iq_pop      (iq_pop)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are changed and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc,
                            input logic [31:0] pred, input logic [31:0] inst);
    check({tag, "_valid"}, {31'd0, iq_valid}, 32'd1);
    check({tag, "_pc"},    iq_pc,      pc);
    check({tag, "_pred"},  iq_pred_pc, pred);
    check({tag, "_inst"},  iq_inst,    inst);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; redirect_pc = 32'h0;
    inst_ready = 1'b0; inst_res = INST_NOP; iq_pop = 1'b0;

    // Reset, held two cycles
    #1;
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    check("rst_inst_valid2", {31'd0, inst_valid}, 32'd0);
    check("rst_iq_valid", {31'd0, iq_valid}, 32'd0);
    check("rst_addr", inst_addr, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("post_rst_addr", inst_addr, 32'h0);
    check("post_rst_iq_inst", iq_inst, 32'h0);

    // Sequential hits, no pops: four accepts fill the queue
    inst_ready = 1'b1; inst_res = INST_NOP;
    tick();
    check_head("hit1", 32'h0, 32'h4, INST_NOP);
    check("hit1_addr", inst_addr, 32'h4);
    tick(); tick(); tick();
    check("full_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("full_addr", inst_addr, 32'h10);
    check_head("full_head", 32'h0, 32'h4, INST_NOP);
    tick();
    check("full_hold_addr", inst_addr, 32'h10);

    // Drain and verify entry order
    inst_ready = 1'b0; iq_pop = 1'b1;
    tick();
    check("pop_reopens_valid", {31'd0, inst_valid}, 32'd1);
    check_head("q1", 32'h4, 32'h8, INST_NOP);
    tick();
    check_head("q2", 32'h8, 32'hC, INST_NOP);
    tick();
    check_head("q3", 32'hC, 32'h10, INST_NOP);
    tick();
    check("drained_iq_valid", {31'd0, iq_valid}, 32'd0);
    check("drained_iq_pc", iq_pc, 32'h0);
    tick();
    check("pop_empty_iq_valid", {31'd0, iq_valid}, 32'd0);

    // JAL forward at pc 0x10
    iq_pop = 1'b0; inst_ready = 1'b1; inst_res = 32'h0100006F;
    tick();
    check_head("jal_fwd", 32'h10, 32'h20, 32'h0100006F);
    check("jal_fwd_addr", inst_addr, 32'h20);
    inst_ready = 1'b0; iq_pop = 1'b1;
    tick();
    iq_pop = 1'b0;

    // Redirect to 0x40 then JAL backward
    clear = 1'b1; redirect_pc = 32'h40;
    #1;
    check("clear_inst_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    clear = 1'b0;
    #1;
    check("redir_addr", inst_addr, 32'h40);
    inst_ready = 1'b1; inst_res = 32'hFF9FF06F;
    tick();
    check_head("jal_bwd", 32'h40, 32'h38, 32'hFF9FF06F);
    check("jal_bwd_addr", inst_addr, 32'h38);
    inst_ready = 1'b0; iq_pop = 1'b1;
    tick();
    iq_pop = 1'b0;

    // Miss: five cycles without inst_ready, address must hold
    for (int i = 0; i < 5; i++) begin
      check("miss_addr", inst_addr, 32'h38);
      check("miss_valid", {31'd0, inst_valid}, 32'd1);
      check("miss_no_push", {31'd0, iq_valid}, 32'd0);
      tick();
    end
    inst_ready = 1'b1; inst_res = INST_NOP;
    tick();
    inst_ready = 1'b0;
    check_head("miss_fill", 32'h38, 32'h3C, INST_NOP);
    check("miss_fill_addr", inst_addr, 32'h3C);
    iq_pop = 1'b1;
    tick();
    check("miss_one_entry", {31'd0, iq_valid}, 32'd0);
    iq_pop = 1'b0;

    // Fill to count 3, then accept and pop together
    inst_ready = 1'b1;
    tick(); tick(); tick();
    check("cnt3_addr", inst_addr, 32'h48);
    iq_pop = 1'b1;
    tick();
    check("pushpop_valid", {31'd0, inst_valid}, 32'd1);
    check_head("pushpop_head", 32'h40, 32'h44, INST_NOP);
    iq_pop = 1'b0;
    tick();
    check("pushpop_then_full", {31'd0, inst_valid}, 32'd0);
    check("pushpop_full_addr", inst_addr, 32'h50);

    // Stall while full
    rdy = 1'b0; iq_pop = 1'b1; inst_ready = 1'b1;
    tick(); tick(); tick();
    check_head("stall_full_head", 32'h40, 32'h44, INST_NOP);
    check("stall_full_addr", inst_addr, 32'h50);

    // Pop once to count 3, then stall with an open request
    rdy = 1'b1; inst_ready = 1'b0;
    tick();
    check_head("pre_stall_head", 32'h44, 32'h48, INST_NOP);
    rdy = 1'b0; inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", inst_addr, 32'h50);
      check("stall_head_pc", iq_pc, 32'h44);
    end
    rdy = 1'b1; iq_pop = 1'b0;
    tick();
    check("stall_cnt_kept", {31'd0, inst_valid}, 32'd0);
    check_head("stall_after", 32'h44, 32'h48, INST_NOP);
    check("stall_after_addr", inst_addr, 32'h54);

    // Flush while full with a pop and ready in the same cycle
    clear = 1'b1; redirect_pc = 32'h100; iq_pop = 1'b1; inst_ready = 1'b1;
    tick();
    clear = 1'b0; iq_pop = 1'b0; inst_ready = 1'b0;
    #1;
    check("flush_iq_valid", {31'd0, iq_valid}, 32'd0);
    check("flush_addr", inst_addr, 32'h100);
    check("flush_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("flush_iq_pc", iq_pc, 32'h0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check_head("post_flush", 32'h100, 32'h104, INST_NOP);
    iq_pop = 1'b1;
    tick();
    iq_pop = 1'b0;
    check("no_stale_entry", {31'd0, iq_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
